// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register word addresses and edge-type
// encodings used by the EDGE_TYPE parameter.
package pio_pkg;

   localparam int unsigned PIO_ADDR_W = 3;

   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA     = 3'd0;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQ_MASK = 3'd2;
   localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGE_CAP = 3'd3;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_filter.sv
// Input conditioning for the PIO: a SYNC_STAGES-deep synchronizer on every
// bit, optionally followed by a per-bit debouncer (macro PIO_IN_DEBOUNCE_EN).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : asynchronous external inputs (WIDTH bits)
//   filt         : synchronized (and debounced if compiled in) inputs
module pio_in_filter #(
   parameter int unsigned WIDTH           = 10,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] filt
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;

   // Synchronizer chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [WIDTH-1:0] filt_q;

   // Counter runs only while sync disagrees with filt; any return to agreement
   // restarts it, so only a level held DEBOUNCE_CYCLES cycles is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= '0;
         for (int b = 0; b < int'(WIDTH); b++) cnt_q[b] <= '0;
      end else begin
         for (int b = 0; b < int'(WIDTH); b++) begin
            if (sync[b] == filt_q[b]) begin
               cnt_q[b] <= '0;
            end else if (cnt_q[b] == CNT_MAX) begin
               filt_q[b] <= sync[b];
               cnt_q[b]  <= '0;
            end else begin
               cnt_q[b] <= cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync;
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture and masked level interrupt.
// Optional debounce stage enabled by defining PIO_IN_DEBOUNCE_EN.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata  : Avalon-MM slave write/address side
//   readdata            : registered read data, latency 1
//   in_port             : asynchronous external inputs
//   irq                 : level interrupt, |(edge_cap & irq_mask)
module pio_in_edge_irq
   import pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 10,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] edge_cap_q;
   logic [2:0]       arm_cnt_q;
   logic             armed;
   logic             wr_en;
   logic [WIDTH-1:0] det_raw;
   logic [WIDTH-1:0] det;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   pio_in_filter #(
      .WIDTH           (WIDTH),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .filt    (filt)
   );

   assign wr_en = chipselect & ~write_n;
   assign armed = (arm_cnt_q == ARM_MAX);

   // Edge detection, suppressed until the synchronizer has flushed after reset
   always_comb begin
      det_raw = filt & ~prev_q;
      if (EDGE_TYPE == EDGE_FALLING) begin
         det_raw = ~filt & prev_q;
      end else if (EDGE_TYPE == EDGE_ANY) begin
         det_raw = filt ^ prev_q;
      end
      det = armed ? det_raw : '0;
   end

   // Write-1-to-clear mask for the capture register
   always_comb begin
      clr = '0;
      if (wr_en && (address == PIO_ADDR_EDGE_CAP)) begin
         clr = writedata[WIDTH-1:0];
      end
   end

   // Read mux; unmapped addresses return zero
   always_comb begin
      rd_mux = '0;
      case (address)
         PIO_ADDR_DATA:     rd_mux = 32'(filt);
         PIO_ADDR_IRQ_MASK: rd_mux = 32'(irq_mask_q);
         PIO_ADDR_EDGE_CAP: rd_mux = 32'(edge_cap_q);
         default:           rd_mux = '0;
      endcase
   end

   // Register file, edge history and arm counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata   <= '0;
         prev_q     <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         arm_cnt_q  <= '0;
      end else begin
         readdata <= rd_mux;
         prev_q   <= filt;
         if (arm_cnt_q != ARM_MAX) begin
            arm_cnt_q <= arm_cnt_q + 3'd1;
         end
         if (wr_en && (address == PIO_ADDR_IRQ_MASK)) begin
            irq_mask_q <= writedata[WIDTH-1:0];
         end
         // A new edge in the same cycle as its clear survives
         edge_cap_q <= (edge_cap_q & ~clr) | det;
      end
   end

   assign irq = |(edge_cap_q & irq_mask_q);

endmodule
